and_stim_gen: RTL and testbench

- Stimulus generator that drives operand buses a and b into the AND-gate DUT and the parallel unknown-state firewall checker in the gate-level testbench.
- Produces deterministic vector sequences: exhaustive, walking-one, pseudo-random and corner.
- Sequences are paced by a valid/stall handshake, so a downstream scoreboard can throttle them.
- Outputs are never X/Z after reset, so any firewall firing is attributable to the DUT path.

---
 rtl/and_stim_pkg.sv | 26 ++
 rtl/lfsr32.sv | 26 ++
 rtl/and_stim_gen.sv | 146 ++++++++++++++
 tb/tb_and_stim_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/and_stim_pkg.sv
// Shared types and constants for the AND-gate stimulus generator.
// Imported by the LFSR and the generator top.
package and_stim_pkg;

    localparam int          MAX_WIDTH = 8;
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    typedef enum logic [1:0] {
        MODE_EXH    = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_RAND   = 2'd2,
        MODE_CORNER = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One right-shifting Galois step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with load and advance controls.
// A zero seed would lock the register at zero, so it is replaced by 1.
module lfsr32
    import and_stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] q
);

    logic [31:0] seed_nz;

    assign seed_nz = (seed == 32'h0) ? 32'h1 : seed;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= seed_nz;
        end else if (advance) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/and_stim_gen.sv
// Operand stimulus generator for the AND-gate DUT: exhaustive, walking-one,
// pseudo-random and corner sequences, paced by a valid/stall handshake.
module and_stim_gen
    import and_stim_pkg::*;
#(
    parameter int          WIDTH      = 1,
    parameter int          RAND_COUNT = 64,
    parameter logic [31:0] SEED       = 32'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             stall,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [15:0]      vec_count
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("and_stim_gen: WIDTH must be in 1..8");
    end
    if (RAND_COUNT < 1 || RAND_COUNT > 65535) begin : g_bad_count
        $error("and_stim_gen: RAND_COUNT must be in 1..65535");
    end

    // Handshake: a vector is consumed on any rising edge where valid=1 and
    // stall=0; a/b stay stable until then and the next vector follows a cycle later.

    localparam logic [16:0]      EXH_LAST  = 17'((32'd1 << (2 * WIDTH)) - 32'd1);
    localparam logic [16:0]      WALK_LAST = 17'(2 * WIDTH - 1);
    localparam logic [16:0]      RAND_LAST = 17'(RAND_COUNT - 1);
    localparam logic [16:0]      W17       = 17'(WIDTH);
    localparam logic [WIDTH-1:0] ONES      = '1;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t      state;
    mode_t       mode_q;
    logic [16:0] idx;
    logic [16:0] last_idx;
    logic [16:0] walk_pos;
    logic [31:0] lfsr_q;
    logic        consume;
    logic        start_ok;

    assign start_ok = (state == ST_IDLE) && start;
    assign consume  = (state == ST_RUN) && !stall;

    lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (start_ok),
        .seed    (SEED),
        .advance (consume && (mode_q == MODE_RAND)),
        .q       (lfsr_q)
    );

    always_comb begin
        last_idx = 17'd3;
        case (mode_q)
            MODE_EXH:    last_idx = EXH_LAST;
            MODE_WALK:   last_idx = WALK_LAST;
            MODE_RAND:   last_idx = RAND_LAST;
            MODE_CORNER: last_idx = 17'd3;
            default:     last_idx = 17'd3;
        endcase
    end

    // Operands decode from the registered index/LFSR; forced to zero outside RUN.
    always_comb begin
        a        = '0;
        b        = '0;
        walk_pos = (idx < W17) ? idx : (idx - W17);
        if (state == ST_RUN) begin
            case (mode_q)
                MODE_EXH: {a, b} = idx[2*WIDTH-1:0];
                MODE_WALK: begin
                    if (idx < W17) begin
                        a = ONE << walk_pos[3:0];
                        b = ONES;
                    end else begin
                        a = ONES;
                        b = ONE << walk_pos[3:0];
                    end
                end
                MODE_RAND: begin
                    a = lfsr_q[WIDTH-1:0];
                    b = lfsr_q[16+WIDTH-1:16];
                end
                MODE_CORNER: begin
                    a = idx[1] ? ONES : '0;
                    b = idx[0] ? ONES : '0;
                end
                default: begin
                    a = '0;
                    b = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_EXH;
            idx       <= '0;
            vec_count <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q    <= mode_t'(mode);
                        idx       <= '0;
                        vec_count <= '0;
                        valid     <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        vec_count <= vec_count + 16'd1;
                        if (idx == last_idx) begin
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + 17'd1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_stim_gen.sv
// Bench for and_stim_gen: three widths (1, 4, 8 with zero seed), random stall,
// expected vector streams generated from the sequence rules.
module tb_and_stim_gen;

    logic clk = 1'b0;
    logic rst;
    logic [2:0]      start_v;
    logic [2:0]      stall_v;
    logic [2:0][1:0] mode_v;

    logic [0:0]  a0, b0;
    logic [3:0]  a1, b1;
    logic [7:0]  a2, b2;
    logic        valid0, valid1, valid2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] vc0, vc1, vc2;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    and_stim_gen #(.WIDTH(1), .RAND_COUNT(64), .SEED(32'hACE1)) u_w1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]), .stall(stall_v[0]),
        .a(a0), .b(b0), .valid(valid0), .busy(busy0), .done(done0), .vec_count(vc0));

    and_stim_gen #(.WIDTH(4), .RAND_COUNT(64), .SEED(32'hACE1)) u_w4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]), .stall(stall_v[1]),
        .a(a1), .b(b1), .valid(valid1), .busy(busy1), .done(done1), .vec_count(vc1));

    and_stim_gen #(.WIDTH(8), .RAND_COUNT(64), .SEED(32'h0)) u_w8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode_v[2]), .stall(stall_v[2]),
        .a(a2), .b(b2), .valid(valid2), .busy(busy2), .done(done2), .vec_count(vc2));

    function automatic int wid(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 8;
    endfunction

    function automatic logic [31:0] seed_of(input int k);
        return (k == 2) ? 32'h0 : 32'hACE1;
    endfunction

    function automatic logic [15:0] get_ab(input int k);
        case (k)
            0:       return {7'b0, a0, 7'b0, b0};
            1:       return {4'b0, a1, 4'b0, b1};
            default: return {a2, b2};
        endcase
    endfunction

    // {valid, busy, done}
    function automatic logic [2:0] get_flags(input int k);
        case (k)
            0:       return {valid0, busy0, done0};
            1:       return {valid1, busy1, done1};
            default: return {valid2, busy2, done2};
        endcase
    endfunction

    function automatic logic [15:0] get_vc(input int k);
        case (k)
            0:       return vc0;
            1:       return vc1;
            default: return vc2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_ent(input int av, input int bv);
        logic [7:0] a8, b8;
        a8 = av[7:0];
        b8 = bv[7:0];
        exp_q.push_back({a8, b8});
    endtask

    // Reference stream straight from the sequence definitions.
    task automatic build_exp(input int k, input int m);
        int w, mask;
        logic [31:0] s;
        w    = wid(k);
        mask = (1 << w) - 1;
        exp_q.delete();
        case (m)
            0: for (int i = 0; i < (1 << (2 * w)); i++) push_ent((i >> w) & mask, i & mask);
            1: begin
                for (int i = 0; i < w; i++) push_ent(1 << i, mask);
                for (int i = 0; i < w; i++) push_ent(mask, 1 << i);
            end
            2: begin
                s = (seed_of(k) == 32'h0) ? 32'h1 : seed_of(k);
                for (int i = 0; i < 64; i++) begin
                    push_ent(int'(s) & mask, int'(s >> 16) & mask);
                    s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
                end
            end
            default: begin
                push_ent(0, 0);
                push_ent(0, mask);
                push_ent(mask, 0);
                push_ent(mask, mask);
            end
        endcase
    endtask

    task automatic run_seq(input int k, input int m, input int stall_pct,
                           input int hold_at, input bit junk);
        int n, consumed, hold_left, cyc;
        logic st;
        logic [2:0] fl;
        build_exp(k, m);
        n         = exp_q.size();
        consumed  = 0;
        hold_left = 3;
        cyc       = 0;
        @(negedge clk);
        mode_v[k]  = 2'(m);
        start_v[k] = 1'b1;
        stall_v[k] = 1'b0;
        @(negedge clk);
        start_v[k] = 1'b0;
        fl = get_flags(k);
        check("first_valid", 32'(fl[2]), 32'd1);
        while (1) begin
            fl = get_flags(k);
            if (fl[0]) break;
            if (cyc > n * 8 + 50) begin
                check("timeout", 32'd1, 32'd0);
                break;
            end
            if (fl[2]) begin
                if (exp_q.size() == 0) check("extra_vec", 32'd1, 32'd0);
                else                   check("vec", 32'(get_ab(k)), 32'(exp_q[0]));
                check("vec_count", 32'(get_vc(k)), 32'(consumed[15:0]));
                check("busy_run", 32'(fl[1]), 32'd1);
                if (consumed == hold_at && hold_left > 0) begin
                    st = 1'b1;
                    hold_left--;
                end else begin
                    st = ($urandom_range(99) < stall_pct);
                end
                stall_v[k] = st;
                if (!st && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    consumed++;
                end
                if (junk && $urandom_range(7) == 0) begin
                    start_v[k] = 1'b1;
                    mode_v[k]  = 2'($urandom_range(3));
                end
            end else begin
                check("valid_in_run", 32'(fl), 32'b110);
            end
            @(negedge clk);
            start_v[k] = 1'b0;
            cyc++;
        end
        fl = get_flags(k);
        check("remaining", 32'(exp_q.size()), 32'd0);
        check("done_flags", 32'(fl), 32'b001);
        check("done_count", 32'(get_vc(k)), 32'(16'(n)));
        check("done_ab", 32'(get_ab(k)), 32'd0);
        stall_v[k] = 1'b0;
        if (junk) begin
            start_v[k] = 1'b1;
            mode_v[k]  = 2'($urandom_range(3));
        end
        @(negedge clk);
        start_v[k] = 1'b0;
        check("after_done", 32'(get_flags(k)), 32'b000);
        check("held_count", 32'(get_vc(k)), 32'(16'(n)));
    endtask

    task automatic mid_reset();
        int cyc;
        @(negedge clk);
        mode_v[1]  = 2'd0;
        start_v[1] = 1'b1;
        stall_v[1] = 1'b0;
        @(negedge clk);
        start_v[1] = 1'b0;
        cyc = 0;
        while (get_vc(1) != 16'd5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_vec5", 32'(get_vc(1)), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_flags", 32'(get_flags(1)), 32'b000);
        check("rst_ab", 32'(get_ab(1)), 32'd0);
        check("rst_count", 32'(get_vc(1)), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_done", 32'(get_flags(1)), 32'b000);
    endtask

    // X/Z firewall and idle-zero watch on every instance.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                check("no_x", 32'($isunknown({get_ab(k), get_flags(k), get_vc(k)})), 32'd0);
                if (get_flags(k)[2] == 1'b0) check("idle_ab", 32'(get_ab(k)), 32'd0);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        start_v = '0;
        stall_v = '0;
        mode_v  = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_flags", 32'(get_flags(k)), 32'b000);
            check("reset_ab", 32'(get_ab(k)), 32'd0);
            check("reset_count", 32'(get_vc(k)), 32'd0);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        run_seq(0, 0, 0, -1, 1'b0);
        run_seq(1, 3, 0, 1, 1'b0);
        run_seq(1, 2, 30, -1, 1'b0);
        run_seq(1, 2, 30, -1, 1'b0);
        run_seq(1, 1, 20, -1, 1'b1);
        for (int m = 0; m < 4; m++) run_seq(0, m, 40, -1, 1'b1);
        mid_reset();
        run_seq(1, 0, 25, -1, 1'b0);
        run_seq(2, 3, 30, 0, 1'b1);
        run_seq(2, 1, 30, -1, 1'b1);
        run_seq(2, 2, 30, -1, 1'b0);
        run_seq(2, 0, 0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
